// File: rtl/rw_mem_checked.sv
// Register memory with fixed-latency read pipeline, write-first forwarding
// and sticky detection of back-to-back writes to the same address.
module rw_mem_checked #(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 4,
  parameter int RD_LAT        = 1,
  parameter int SAME_ADDR_ERR = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              read,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rd_served,
  output logic              rd_uninit,
  output logic              err_consec_wr,
  output logic [ADDR_W-1:0] err_addr
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  written;

  logic [DATA_W-1:0] snap_data;
  logic              snap_uninit;

  logic [RD_LAT-1:0] pipe_valid;
  logic [RD_LAT-1:0] pipe_uninit;
  logic [DATA_W-1:0] pipe_data [RD_LAT];

  // A same-cycle write to the read address wins over the stored value.
  always_comb begin
    snap_data   = mem[raddr];
    snap_uninit = ~written[raddr];
    if (wr_valid && (waddr == raddr)) begin
      snap_data   = wdata;
      snap_uninit = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      written <= '0;
    end else if (wr_valid) begin
      mem[waddr]     <= wdata;
      written[waddr] <= 1'b1;
    end
  end

  // Data stages load only on a valid read, so the last stage holds the
  // most recently served value while the pipeline is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid  <= '0;
      pipe_uninit <= '0;
      for (int k = 0; k < RD_LAT; k++) pipe_data[k] <= '0;
    end else begin
      pipe_valid[0]  <= read;
      pipe_uninit[0] <= read & snap_uninit;
      if (read) pipe_data[0] <= snap_data;
      for (int k = 1; k < RD_LAT; k++) begin
        pipe_valid[k]  <= pipe_valid[k-1];
        pipe_uninit[k] <= pipe_uninit[k-1];
        if (pipe_valid[k-1]) pipe_data[k] <= pipe_data[k-1];
      end
    end
  end

  assign rdata     = pipe_data[RD_LAT-1];
  assign rd_served = pipe_valid[RD_LAT-1];
  assign rd_uninit = pipe_uninit[RD_LAT-1];

  generate
    if (SAME_ADDR_ERR != 0) begin : g_chk
      logic              prev_wr_valid;
      logic [ADDR_W-1:0] prev_waddr;

      // err_addr freezes on the first violation; only reset clears it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prev_wr_valid <= 1'b0;
          prev_waddr    <= '0;
          err_consec_wr <= 1'b0;
          err_addr      <= '0;
        end else begin
          prev_wr_valid <= wr_valid;
          prev_waddr    <= waddr;
          if (wr_valid && prev_wr_valid && (waddr == prev_waddr) && !err_consec_wr) begin
            err_consec_wr <= 1'b1;
            err_addr      <= waddr;
          end
        end
      end
    end else begin : g_nochk
      assign err_consec_wr = 1'b0;
      assign err_addr      = '0;
    end
  endgenerate

endmodule

// File: tb/tb_rw_mem_checked.sv
// Directed bench: one RD_LAT=4 checked instance and one RD_LAT=1 unchecked
// instance share the same stimulus.
module tb_rw_mem_checked;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic [3:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        read = 1'b0;
  logic [3:0]  raddr = '0;

  logic [31:0] rdata4, rdata1;
  logic        served4, served1, uninit4, uninit1, err4, err1;
  logic [3:0]  erra4, erra1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rw_mem_checked #(.DATA_W(32), .ADDR_W(4), .RD_LAT(4), .SAME_ADDR_ERR(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .waddr(waddr), .wdata(wdata),
    .read(read), .raddr(raddr), .rdata(rdata4), .rd_served(served4),
    .rd_uninit(uninit4), .err_consec_wr(err4), .err_addr(erra4)
  );

  rw_mem_checked #(.DATA_W(32), .ADDR_W(4), .RD_LAT(1), .SAME_ADDR_ERR(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .waddr(waddr), .wdata(wdata),
    .read(read), .raddr(raddr), .rdata(rdata1), .rd_served(served1),
    .rd_uninit(uninit1), .err_consec_wr(err1), .err_addr(erra1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wv, input logic [3:0] wa, input logic [31:0] wd,
                       input logic rv, input logic [3:0] ra);
    wr_valid = wv;
    waddr    = wa;
    wdata    = wd;
    read     = rv;
    raddr    = ra;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
  endtask

  task automatic rd_cycle(input logic wv, input logic [3:0] wa, input logic [31:0] wd,
                          input logic [3:0] ra, input logic [31:0] exp_d, input logic exp_u);
    drive(wv, wa, wd, 1'b1, ra);
    tick();
    idle();
    check("lat1_served", served1, 1);
    check("lat1_data", rdata1, exp_d);
    check("lat1_uninit", uninit1, exp_u);
    check("lat4_early", served4, 0);
    tick();
    check("lat1_done", served1, 0);
    check("lat1_hold", rdata1, exp_d);
    tick();
    tick();
    check("lat4_served", served4, 1);
    check("lat4_data", rdata4, exp_d);
    check("lat4_uninit", uninit4, exp_u);
    tick();
    check("lat4_done", served4, 0);
    check("lat4_uninit_idle", uninit4, 0);
    check("lat4_hold", rdata4, exp_d);
  endtask

  // 16 back-to-back reads of 0..15; data is addr+0x100 unless expecting a wiped array.
  task automatic stream(input logic wiped);
    logic [31:0] exp_d;
    for (int k = 0; k < 19; k++) begin
      if (k < 16) drive(1'b0, 4'd0, 32'd0, 1'b1, 4'(k));
      else idle();
      tick();
      if (k < 16) begin
        exp_d = wiped ? 32'd0 : 32'h100 + 32'(k);
        check("str1_served", served1, 1);
        check("str1_data", rdata1, exp_d);
        check("str1_uninit", uninit1, wiped);
      end
      if (k >= 3) begin
        exp_d = wiped ? 32'd0 : 32'h100 + 32'(k - 3);
        check("str4_served", served4, 1);
        check("str4_data", rdata4, exp_d);
        check("str4_uninit", uninit4, wiped);
      end else begin
        check("str4_pre", served4, 0);
      end
    end
    tick();
    check("str4_post", served4, 0);
  endtask

  initial begin
    tick();
    tick();
    check("rst_rdata", rdata4, 0);
    check("rst_served", served4, 0);
    check("rst_uninit", uninit4, 0);
    check("rst_err", err4, 0);
    check("rst_erraddr", erra4, 0);
    check("rst_served1", served1, 0);
    rst_n = 1'b1;
    tick();

    rd_cycle(1'b0, 4'd0, 32'd0, 4'd3, 32'd0, 1'b1);

    drive(1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 4'd0);
    tick();
    idle();
    tick();
    rd_cycle(1'b0, 4'd0, 32'd0, 4'd5, 32'hDEADBEEF, 1'b0);

    // Overwrite addr 5 while a read of it is in flight.
    drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd5);
    tick();
    check("win1_data", rdata1, 32'hDEADBEEF);
    drive(1'b1, 4'd5, 32'h1, 1'b0, 4'd0);
    tick();
    idle();
    tick();
    tick();
    check("win4_served", served4, 1);
    check("win4_data", rdata4, 32'hDEADBEEF);
    tick();
    rd_cycle(1'b0, 4'd0, 32'd0, 4'd5, 32'h1, 1'b0);

    rd_cycle(1'b1, 4'd7, 32'hA5A5A5A5, 4'd7, 32'hA5A5A5A5, 1'b0);

    drive(1'b1, 4'd4, 32'h44, 1'b0, 4'd0);
    tick();
    idle();
    tick();
    drive(1'b1, 4'd4, 32'h45, 1'b0, 4'd0);
    tick();
    idle();
    tick();
    check("gap_noflag", err4, 0);
    drive(1'b1, 4'd3, 32'h33, 1'b0, 4'd0);
    tick();
    drive(1'b1, 4'd6, 32'h66, 1'b0, 4'd0);
    tick();
    idle();
    tick();
    check("diff_noflag", err4, 0);
    drive(1'b1, 4'd2, 32'h11, 1'b0, 4'd0);
    tick();
    check("first_wr_noflag", err4, 0);
    drive(1'b1, 4'd2, 32'h22, 1'b0, 4'd0);
    tick();
    idle();
    check("consec_flag", err4, 1);
    check("consec_addr", erra4, 2);
    check("disabled_flag", err1, 0);
    check("disabled_addr", erra1, 0);
    tick();
    drive(1'b1, 4'd9, 32'h99, 1'b0, 4'd0);
    tick();
    drive(1'b1, 4'd9, 32'h9A, 1'b0, 4'd0);
    tick();
    idle();
    tick();
    check("sticky_flag", err4, 1);
    check("sticky_addr", erra4, 2);
    check("disabled_flag2", err1, 0);
    rd_cycle(1'b0, 4'd0, 32'd0, 4'd2, 32'h22, 1'b0);

    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'(i), 32'h100 + 32'(i), 1'b0, 4'd0);
      tick();
    end
    idle();
    tick();
    stream(1'b0);

    // Reset lands while three reads are still in the RD_LAT=4 pipeline.
    drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd1);
    tick();
    drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd2);
    tick();
    drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd3);
    tick();
    idle();
    check("pre_rst_inflight", served4, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rdata", rdata4, 0);
    check("mid_rst_served", served4, 0);
    check("mid_rst_err", err4, 1'b0);
    check("mid_rst_erraddr", erra4, 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_served4", served4, 0);
      check("post_rst_served1", served1, 0);
    end
    check("post_rst_rdata", rdata4, 0);
    stream(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
